// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback arbiter: width defaults,
// the hard-wired zero register and the requester identifiers.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  typedef enum logic [0:0] {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

endpackage

// File: rtl/wb_fifo.sv
// Per-requester writeback queue: circular buffer of {addr, data} entries with
// per-slot valid bits so the owner can build a pending-write mask.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [ADDR_W-1:0]        head_addr,
  output logic [DATA_W-1:0]        head_data,
  output logic [DEPTH*ADDR_W-1:0]  ent_addr,
  output logic [DEPTH-1:0]         ent_valid
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_r [DEPTH];
  logic [DATA_W-1:0] data_r [DEPTH];
  logic [DEPTH-1:0]  valid_r;
  logic [DEPTH-1:0]  valid_next_s;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic              push_s;
  logic              pop_s;

  // A full queue refuses a push even if it is popped on the same edge.
  assign full   = &valid_r;
  assign empty  = ~|valid_r;
  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;

  assign head_addr = addr_r[rd_ptr_r];
  assign head_data = data_r[rd_ptr_r];
  assign ent_valid = valid_r;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign ent_addr[g*ADDR_W +: ADDR_W] = addr_r[g];
  end

  // Slot occupancy after this edge: pop frees the head, push claims the tail.
  always_comb begin
    valid_next_s = (valid_r & ~(DEPTH'(pop_s) << rd_ptr_r)) | (DEPTH'(push_s) << wr_ptr_r);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      valid_r <= valid_next_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= '0;
        data_r[i] <= '0;
      end
    end else if (push_s) begin
      addr_r[wr_ptr_r] <= push_addr;
      data_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port between the ALU and load
// writeback paths through two queues and a round-robin arbiter.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDR_W-1:0]    alu_addr,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_data,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic [2**ADDR_W-1:0] pend_mask,
  output logic                 busy
);

  localparam int NREG = 2**ADDR_W;

  logic                         alu_full_s, alu_empty_s, alu_pop_s;
  logic                         mem_full_s, mem_empty_s, mem_pop_s;
  logic [ADDR_W-1:0]            alu_head_addr_s, mem_head_addr_s;
  logic [DATA_W-1:0]            alu_head_data_s, mem_head_data_s;
  logic [FIFO_DEPTH*ADDR_W-1:0] alu_ent_addr_s, mem_ent_addr_s;
  logic [FIFO_DEPTH-1:0]        alu_ent_valid_s, mem_ent_valid_s;
  logic [NREG-1:0]              pend_s;
  req_id_e                      last_grant_r;
  logic                         rf_we_r;
  logic [ADDR_W-1:0]            rf_waddr_r;
  logic [DATA_W-1:0]            rf_wdata_r;

  assign alu_ready = ~alu_full_s;
  assign mem_ready = ~mem_full_s;

  wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_alu_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (alu_valid),
    .push_addr (alu_addr),
    .push_data (alu_data),
    .pop       (alu_pop_s),
    .full      (alu_full_s),
    .empty     (alu_empty_s),
    .head_addr (alu_head_addr_s),
    .head_data (alu_head_data_s),
    .ent_addr  (alu_ent_addr_s),
    .ent_valid (alu_ent_valid_s)
  );

  wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_mem_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (mem_valid),
    .push_addr (mem_addr),
    .push_data (mem_data),
    .pop       (mem_pop_s),
    .full      (mem_full_s),
    .empty     (mem_empty_s),
    .head_addr (mem_head_addr_s),
    .head_data (mem_head_data_s),
    .ent_addr  (mem_ent_addr_s),
    .ent_valid (mem_ent_valid_s)
  );

  // Round-robin pick: on a tie the requester not granted last wins.
  always_comb begin
    alu_pop_s = 1'b0;
    mem_pop_s = 1'b0;
    case ({alu_empty_s, mem_empty_s})
      2'b00: begin
        alu_pop_s = (last_grant_r == REQ_MEM);
        mem_pop_s = (last_grant_r == REQ_ALU);
      end
      2'b01:   alu_pop_s = 1'b1;
      2'b10:   mem_pop_s = 1'b1;
      default: begin
        alu_pop_s = 1'b0;
        mem_pop_s = 1'b0;
      end
    endcase
  end

  // Write port register; writes to the zero register are popped but dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= REQ_MEM;
      rf_we_r      <= 1'b0;
      rf_waddr_r   <= '0;
      rf_wdata_r   <= '0;
    end else if (alu_pop_s) begin
      last_grant_r <= REQ_ALU;
      rf_we_r      <= (alu_head_addr_s != ADDR_W'(REG_ZERO));
      rf_waddr_r   <= alu_head_addr_s;
      rf_wdata_r   <= alu_head_data_s;
    end else if (mem_pop_s) begin
      last_grant_r <= REQ_MEM;
      rf_we_r      <= (mem_head_addr_s != ADDR_W'(REG_ZERO));
      rf_waddr_r   <= mem_head_addr_s;
      rf_wdata_r   <= mem_head_data_s;
    end else begin
      rf_we_r <= 1'b0;
    end
  end

  // Pending-write mask over both queues plus the write currently on the port.
  always_comb begin
    pend_s = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      pend_s = pend_s | (NREG'(alu_ent_valid_s[i]) << alu_ent_addr_s[i*ADDR_W +: ADDR_W]);
      pend_s = pend_s | (NREG'(mem_ent_valid_s[i]) << mem_ent_addr_s[i*ADDR_W +: ADDR_W]);
    end
    pend_s    = pend_s | (NREG'(rf_we_r) << rf_waddr_r);
    pend_s[0] = 1'b0;
  end

  assign pend_mask = pend_s;
  assign rf_we     = rf_we_r;
  assign rf_waddr  = rf_waddr_r;
  assign rf_wdata  = rf_wdata_r;
  assign busy      = ~alu_empty_s | ~mem_empty_s | rf_we_r;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

- Shares the single register-file write port between two writeback requesters: the ALU result path and the memory-load path.
- Each requester gets a small FIFO with a valid/ready handshake; a round-robin arbiter drains the FIFOs into one registered write port.
- Exports a pending-write mask so the decode/hazard stage can stall readers of registers that still have queued writes.
- Sits between the execute/memory stages and the register file write inputs (RegWrite, write_reg, write_data).

## Interface
Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (2**ADDR_W registers)
- FIFO_DEPTH, 2, entries per requester queue (power of two, ≥2)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU queue can accept
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load writeback request
- mem_ready  out  1  load queue can accept
- mem_addr  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- rf_we  out  1  register file write enable (registered)
- rf_waddr  out  ADDR_W  register file write address (registered)
- rf_wdata  out  DATA_W  register file write data (registered)
- pend_mask  out  2**ADDR_W  bit i set while a write to register i is queued or is on the output port
- busy  out  1  any queue non-empty or rf_we high

## Operation
- Accept: an entry is pushed into a requester's queue on any edge where that requester's valid and ready are both high.
- Ready: x_ready = !full, evaluated from the state before the edge. A full queue never accepts, even when it is popped on the same edge; there is no pass-through.
- Arbitration: each edge, at most one queue head is popped.
  - If only one queue is non-empty, that queue is popped.
  - If both are non-empty, the requester not granted last is popped.
  - The last_grant pointer updates only on a pop.
- Output: the popped head loads rf_waddr and rf_wdata, and rf_we goes to 1.
  - If the head's address is 0, the entry is popped but rf_we is 0 (writes to $zero are dropped).
  - If no pop occurs, rf_we is 0. rf_waddr and rf_wdata hold their previous values.
- pend_mask:
  - Combinational OR of one-hot decodes of every valid queue entry's address, plus rf_waddr when rf_we is high.
  - Bit 0 is forced to 0.
- Ordering:
  - Within one requester, writes leave in FIFO order.
  - Across requesters, no program order is tracked. Upstream must not issue to a register whose pend_mask bit is set. Violating this gives round-robin order, which is deterministic but unspecified.

## Timing
- Reset (rst_n low, asynchronous):
  - Both queues empty, so alu_ready = mem_ready = 1.
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0.
  - pend_mask = 0, busy = 0.
  - last_grant = MEM, so the ALU wins the first tie.
- Latency: an entry accepted at edge N into an empty queue, with no competition, is popped at edge N+1. rf_we is high in the cycle after N+1.
- Throughput: one register write per cycle total. With both requesters streaming, each gets one write every 2 cycles and the queues fill.
- Full: after FIFO_DEPTH accepts with no pops, x_ready drops in the following cycle. It returns to 1 the cycle after a pop.
- Simultaneous push and pop on a non-full, non-empty queue: occupancy is unchanged and order is preserved.
- Reset mid-operation: all queued entries are discarded. rf_we drops immediately (asynchronously), and pend_mask clears with it.

## Structure
- Shared package regfile_pkg holds:
  - DATA_W and ADDR_W defaults
  - REG_ZERO = 0
  - requester id enum {REQ_ALU, REQ_MEM}, used for last_grant
- Sub-module wb_fifo: a parameterized DATA_W+ADDR_W queue of FIFO_DEPTH entries.
  - Exposes push, pop, full, empty and head.
  - Exposes the per-entry address and valid vectors for pend_mask.
  - Instantiated twice, once per requester.
- The arbiter pointer, output register and mask logic live in the top module.

## Test plan
- Reset then single ALU write (addr 8, data 0x12345678) → rf_we=1, rf_waddr=8, rf_wdata=0x12345678 two edges after accept. pend_mask bit 8 is set from the accept until rf_we drops.
- ALU and MEM both valid every cycle (ALU addr 9, MEM addr 16, distinct data) → writes alternate ALU, MEM, ALU, …. After the queues fill, each ready toggles so each requester is accepted every other cycle. No entry is lost or duplicated.
- ALU write to addr 0, data 0xFFFFFFFF → entry is accepted and popped, rf_we stays 0, pend_mask stays 0, and busy returns to 0.
- MEM pushes 3 entries back-to-back with FIFO_DEPTH=2 while the ALU queue is non-empty → mem_ready=0 after the 2nd accept. The 3rd entry is held by the requester until ready returns. Output order is 1, 2, 3.
- Assert rst_n=0 for 1 cycle with both queues full and rf_we=1 → rf_we, pend_mask and busy go to 0 immediately. Both readys are 1 after release. No stale write appears afterwards.
- FIFO_DEPTH=4 regression: ALU streams 4 writes, then MEM writes 1 → ALU output in order, MEM granted on the first tie. pend_mask matches a scoreboard model every cycle.
